cmplx_mac: RTL and testbench

Parametrised, pipelined complex multiply-accumulate for I/Q sample streams. It computes a·b or a·conj(b) per sample and sums N consecutive valid products into one result. It is the successor to the fixed 18-bit complex multiplier and adds a valid qualifier, a per-sample conjugate mode, a configurable accumulation length and a guaranteed overflow-free output width. It sits between the sample-alignment stage and the correlator/detector logic.

---
 rtl/cmplx_mac_if.sv | 46 ++++
 rtl/cmplx_mac.sv | 183 ++++++++++++++++++
 tb/tb_cmplx_mac.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cmplx_mac_if.sv
// Sample/result bus of the complex multiply-accumulate.
// The master drives samples and receives accumulated results; the slave is the MAC.
interface cmplx_mac_if #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned LEN_W  = 8
);
    // Result width is derived so that a full-length frame of full-scale samples cannot wrap.
    localparam int unsigned ACC_W = 2 * DATA_W + 1 + LEN_W;

    logic                     valid_i;
    logic                     conj_i;
    logic signed [DATA_W-1:0] data_a_i_i;
    logic signed [DATA_W-1:0] data_a_q_i;
    logic signed [DATA_W-1:0] data_b_i_i;
    logic signed [DATA_W-1:0] data_b_q_i;
    logic        [LEN_W-1:0]  acc_len_i;
    logic                     valid_o;
    logic signed [ACC_W-1:0]  data_i_o;
    logic signed [ACC_W-1:0]  data_q_o;

    modport master (
        output valid_i,
        output conj_i,
        output data_a_i_i,
        output data_a_q_i,
        output data_b_i_i,
        output data_b_q_i,
        output acc_len_i,
        input  valid_o,
        input  data_i_o,
        input  data_q_o
    );

    modport slave (
        input  valid_i,
        input  conj_i,
        input  data_a_i_i,
        input  data_a_q_i,
        input  data_b_i_i,
        input  data_b_q_i,
        input  acc_len_i,
        output valid_o,
        output data_i_o,
        output data_q_o
    );
endinterface

// File: rtl/cmplx_mac.sv
// Pipelined complex multiply-accumulate: a*b or a*conj(b) per sample, summing N valid
// products into one exact result. Four stages: input register, products, I/Q sums,
// accumulator/output.
module cmplx_mac #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned LEN_W  = 8
) (
    input logic        clk_i,
    input logic        arst_i,
    cmplx_mac_if.slave bus
);
    localparam int unsigned PROD_W = 2 * DATA_W + 1;
    localparam int unsigned ACC_W  = PROD_W + LEN_W;

    // ---------------------------------------------------------------- S1: input register
    logic                     s1_valid_q;
    logic                     s1_conj_q;
    logic signed [DATA_W-1:0] s1_a_i_q;
    logic signed [DATA_W-1:0] s1_a_q_q;
    logic signed [DATA_W-1:0] s1_b_i_q;
    logic signed [DATA_W-1:0] s1_b_q_q;

    // Capture the sample, its qualifier and its own conjugate flag.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1_valid_q <= 1'b0;
            s1_conj_q  <= 1'b0;
            s1_a_i_q   <= '0;
            s1_a_q_q   <= '0;
            s1_b_i_q   <= '0;
            s1_b_q_q   <= '0;
        end else begin
            s1_valid_q <= bus.valid_i;
            s1_conj_q  <= bus.conj_i;
            s1_a_i_q   <= bus.data_a_i_i;
            s1_a_q_q   <= bus.data_a_q_i;
            s1_b_i_q   <= bus.data_b_i_i;
            s1_b_q_q   <= bus.data_b_q_i;
        end
    end

    // ---------------------------------------------------------------- S2: products
    logic signed [PROD_W-1:0] ai_x;
    logic signed [PROD_W-1:0] aq_x;
    logic signed [PROD_W-1:0] bi_x;
    logic signed [PROD_W-1:0] bq_x;
    logic signed [PROD_W-1:0] bq_eff;
    logic signed [PROD_W-1:0] p_ii_d;
    logic signed [PROD_W-1:0] p_qq_d;
    logic signed [PROD_W-1:0] p_iq_d;
    logic signed [PROD_W-1:0] p_qi_d;

    // Operands are widened before negation so that -(-2^(DATA_W-1)) stays exact, and before
    // multiplying so every product is formed at full PROD_W precision.
    always_comb begin
        ai_x   = PROD_W'(s1_a_i_q);
        aq_x   = PROD_W'(s1_a_q_q);
        bi_x   = PROD_W'(s1_b_i_q);
        bq_x   = PROD_W'(s1_b_q_q);
        bq_eff = s1_conj_q ? -bq_x : bq_x;
        p_ii_d = ai_x * bi_x;
        p_qq_d = aq_x * bq_eff;
        p_iq_d = ai_x * bq_eff;
        p_qi_d = aq_x * bi_x;
    end

    logic                     s2_valid_q;
    logic signed [PROD_W-1:0] s2_p_ii_q;
    logic signed [PROD_W-1:0] s2_p_qq_q;
    logic signed [PROD_W-1:0] s2_p_iq_q;
    logic signed [PROD_W-1:0] s2_p_qi_q;

    // Register the four partial products.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s2_valid_q <= 1'b0;
            s2_p_ii_q  <= '0;
            s2_p_qq_q  <= '0;
            s2_p_iq_q  <= '0;
            s2_p_qi_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_p_ii_q  <= p_ii_d;
            s2_p_qq_q  <= p_qq_d;
            s2_p_iq_q  <= p_iq_d;
            s2_p_qi_q  <= p_qi_d;
        end
    end

    // ---------------------------------------------------------------- S3: I/Q sums
    logic                     s3_valid_q;
    logic signed [PROD_W-1:0] s3_sum_i_q;
    logic signed [PROD_W-1:0] s3_sum_q_q;

    // Combine products; conjugation is already folded into the sign of b_q.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s3_valid_q <= 1'b0;
            s3_sum_i_q <= '0;
            s3_sum_q_q <= '0;
        end else begin
            s3_valid_q <= s2_valid_q;
            s3_sum_i_q <= s2_p_ii_q - s2_p_qq_q;
            s3_sum_q_q <= s2_p_iq_q + s2_p_qi_q;
        end
    end

    // ---------------------------------------------------------------- S4: accumulator
    logic        [LEN_W-1:0] cnt_q, cnt_d;
    logic        [LEN_W-1:0] len_q, len_d;
    logic        [LEN_W-1:0] len_eff;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] sum_i_x;
    logic signed [ACC_W-1:0] sum_q_x;
    logic signed [ACC_W-1:0] out_i_q, out_i_d;
    logic signed [ACC_W-1:0] out_q_q, out_q_d;
    logic                    out_valid_q, out_valid_d;

    // Frame control: the length is taken live at the first sample of a frame and then frozen,
    // so acc_len_i changes only take effect on the next frame.
    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_valid_d = 1'b0;
        sum_i_x     = ACC_W'(s3_sum_i_q);
        sum_q_x     = ACC_W'(s3_sum_q_q);

        len_eff = len_q;
        if (cnt_q == '0) begin
            len_eff = (bus.acc_len_i == '0) ? LEN_W'(1) : bus.acc_len_i;
        end

        if (s3_valid_q) begin
            if (cnt_q == '0) begin
                len_d = len_eff;
            end
            if (cnt_q == len_eff - LEN_W'(1)) begin
                // Last sample of the frame: emit and restart.
                out_i_d     = acc_i_q + sum_i_x;
                out_q_d     = acc_q_q + sum_q_x;
                out_valid_d = 1'b1;
                acc_i_d     = '0;
                acc_q_d     = '0;
                cnt_d       = '0;
            end else begin
                acc_i_d = acc_i_q + sum_i_x;
                acc_q_d = acc_q_q + sum_q_x;
                cnt_d   = cnt_q + LEN_W'(1);
            end
        end
    end

    // Accumulator, frame counter, latched length and result registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q       <= '0;
            len_q       <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.valid_o  = out_valid_q;
    assign bus.data_i_o = out_i_q;
    assign bus.data_q_o = out_q_q;

endmodule

// File: tb/tb_cmplx_mac.sv
// Directed bench for cmplx_mac with hand-computed expected results.
module tb_cmplx_mac;
    localparam int unsigned DATA_W = 18;
    localparam int unsigned LEN_W  = 8;
    localparam int          FS     = -131072;

    logic clk_i = 1'b0;
    logic arst_i;
    int   tests = 0;
    int   fails = 0;

    always #5 clk_i = ~clk_i;

    cmplx_mac_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    cmplx_mac #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic signed [63:0] ei,
                             input logic signed [63:0] eq);
        check({tag, ".valid"}, 64'(bus.valid_o), 64'(v));
        check({tag, ".i"}, 64'(bus.data_i_o), ei);
        check({tag, ".q"}, 64'(bus.data_q_o), eq);
    endtask

    // One clock with valid_o required low.
    task automatic quiet(input string tag);
        tick();
        check({tag, ".quiet"}, 64'(bus.valid_o), 64'd0);
    endtask

    task automatic drive(input logic v, input logic c, input int ai, input int aq,
                         input int bi, input int bq);
        bus.valid_i    = v;
        bus.conj_i     = c;
        bus.data_a_i_i = DATA_W'(ai);
        bus.data_a_q_i = DATA_W'(aq);
        bus.data_b_i_i = DATA_W'(bi);
        bus.data_b_q_i = DATA_W'(bq);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        arst_i        = 1'b0;
        bus.acc_len_i = LEN_W'(1);
        idle();

        // Reset state, applied away from any clock edge.
        #2 arst_i = 1'b1;
        #1 check_out("rst_async", 1'b0, 0, 0);
        tick();
        tick();
        check_out("rst_hold", 1'b0, 0, 0);
        #3 arst_i = 1'b0;
        tick();

        // Plain multiply, N=1: (3,4)*(5,-2) = (23,14), four clocks after the sample.
        drive(1'b1, 1'b0, 3, 4, 5, -2);
        tick();
        idle();
        quiet("mul_lat1");
        quiet("mul_lat2");
        tick();
        check_out("mul", 1'b1, 23, 14);
        tick();
        check_out("mul_hold", 1'b0, 23, 14);

        // Conjugate: (3,4)*conj(5,-2) = (7,26).
        drive(1'b1, 1'b1, 3, 4, 5, -2);
        tick();
        idle();
        quiet("conj_lat1");
        quiet("conj_lat2");
        tick();
        check_out("conj", 1'b1, 7, 26);

        // Alternating conj_i on back-to-back samples.
        drive(1'b1, 1'b0, 3, 4, 5, -2);
        tick();
        drive(1'b1, 1'b1, 3, 4, 5, -2);
        tick();
        drive(1'b1, 1'b0, 3, 4, 5, -2);
        tick();
        idle();
        tick();
        check_out("alt0", 1'b1, 23, 14);
        tick();
        check_out("alt1", 1'b1, 7, 26);
        tick();
        check_out("alt2", 1'b1, 23, 14);
        tick();
        check_out("alt_end", 1'b0, 23, 14);

        // Full-scale corner: conj gives (2^35, 0), plain gives (0, 2^35).
        drive(1'b1, 1'b1, FS, FS, FS, FS);
        tick();
        drive(1'b1, 1'b0, FS, FS, FS, FS);
        tick();
        idle();
        quiet("fs_lat");
        tick();
        check_out("fs_conj", 1'b1, 64'sd34359738368, 0);
        tick();
        check_out("fs_plain", 1'b1, 0, 64'sd34359738368);

        // acc_len_i = 0 behaves as N=1.
        bus.acc_len_i = LEN_W'(0);
        drive(1'b1, 1'b0, 3, 4, 5, -2);
        tick();
        idle();
        quiet("len0_lat1");
        quiet("len0_lat2");
        tick();
        check_out("len0", 1'b1, 23, 14);

        // N=4 with random gaps: (1,0)*(k,k), k=1..4, sums to (10,10).
        bus.acc_len_i = LEN_W'(4);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 1, 0, k, k);
            quiet("gap_smp");
            idle();
            if (k < 4) begin
                repeat ($urandom_range(0, 3)) quiet("gap_idle");
            end
        end
        quiet("gap_lat1");
        quiet("gap_lat2");
        tick();
        check_out("gap_acc", 1'b1, 10, 10);
        tick();
        check_out("gap_end", 1'b0, 10, 10);

        // Maximum length, full-scale conj: 255 * 2^35, length change deferred to next frame.
        bus.acc_len_i = LEN_W'(255);
        for (int n = 0; n < 255; n++) begin
            drive(1'b1, 1'b1, FS, FS, FS, FS);
            if (n == 10) bus.acc_len_i = LEN_W'(2);
            quiet("max_smp");
        end
        idle();
        quiet("max_lat1");
        quiet("max_lat2");
        tick();
        check_out("max_acc", 1'b1, 64'sd8761733283840, 0);

        // Next frame uses N=2: 2 * (23,14).
        drive(1'b1, 1'b0, 3, 4, 5, -2);
        quiet("n2_smp0");
        drive(1'b1, 1'b0, 3, 4, 5, -2);
        quiet("n2_smp1");
        idle();
        quiet("n2_lat1");
        quiet("n2_lat2");
        tick();
        check_out("n2_acc", 1'b1, 46, 28);

        // Reset mid-frame, asserted between clock edges.
        bus.acc_len_i = LEN_W'(4);
        drive(1'b1, 1'b0, 1, 0, 1, 1);
        quiet("rstmf_smp0");
        drive(1'b1, 1'b0, 1, 0, 1, 1);
        quiet("rstmf_smp1");
        idle();
        quiet("rstmf_gap");
        #3 arst_i = 1'b1;
        #1 check_out("rstmf_async", 1'b0, 0, 0);
        #1 arst_i = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1, 0, 2, 2);
            quiet("post_smp");
        end
        idle();
        quiet("post_lat1");
        quiet("post_lat2");
        tick();
        check_out("post_acc", 1'b1, 8, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
